mem_access_stage: RTL and testbench

- MEM-stage data-memory access controller.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Issues load/store transactions on a req/ack data-memory bus, generates byte enables, and aligns/sign-extends load data.
- Stalls upstream until the memory transaction completes, and drives a bubble toward MEM/WB while stalled.

---
 rtl/mem_access_stage_pkg.sv | 44 ++++
 rtl/mem_access_stage_load_align.sv | 39 +++
 rtl/mem_access_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_stage_pkg
// Brief  : Shared opcodes, FSM encoding and lane helpers for the MEM stage.
// Rev    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam int TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] byte_enable(input logic [5:0] op, input logic [1:0] addr);
        case (op)
            OP_LB, OP_LBU, OP_SB: byte_enable = 4'b0001 << addr;
            OP_LH, OP_LHU, OP_SH: byte_enable = addr[1] ? 4'b1100 : 4'b0011;
            default:              byte_enable = 4'b1111;
        endcase
    endfunction

    // Lane replication lets the memory pick the lane purely from mem_be.
    function automatic logic [31:0] store_lanes(input logic [5:0] op, input logic [31:0] data);
        case (op)
            OP_SB:   store_lanes = {4{data[7:0]}};
            OP_SH:   store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module : mem_load_align
// Brief  : Selects the addressed load lane and sign/zero-extends it to 32 bits.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (addr)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        w_half = addr[1] ? word[31:16] : word[15:0];

        case (opcode)
            OP_LB:   data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  data = {24'd0, w_byte};
            OP_LH:   data = {{16{w_half[15]}}, w_half};
            OP_LHU:  data = {16'd0, w_half};
            default: data = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module : mem_access_stage
// Brief  : MEM-stage req/ack data-memory controller with stall and bubble.
//          Optional MEM_ALIGN_CHECK_EN adds misalignment trapping (align_err).
// Rev    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        regWrite,
    input  logic        memtoReg,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] ALU_result,
    input  logic [31:0] storeData,
    input  logic [4:0]  WN,
    output logic        stall_out,
    output logic [5:0]  opcode_out,
    output logic [5:0]  funct_out,
    output logic        regWrite_out,
    output logic        memtoReg_out,
    output logic [31:0] dataMemrd,
    output logic [31:0] ALU_result_out,
    output logic [4:0]  WN_out,
    output logic        bus_err,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        align_err,
`endif
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [TIMEOUT_W-1:0] c_TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t                 r_state;
    logic [TIMEOUT_W-1:0]   r_cnt;
    logic [31:0]            r_rdata;
    logic                   r_bus_err;
    logic                   r_align_err;
    logic                   w_mem_op;
    logic                   w_misaligned;
    logic [31:0]            w_load_data;

    assign w_mem_op = valid_in & (memRead | memWrite);
    assign bus_err  = r_bus_err;

`ifdef MEM_ALIGN_CHECK_EN
    logic w_is_half;
    logic w_is_word;
    assign w_is_half    = (opcode == OP_LH) | (opcode == OP_LHU) | (opcode == OP_SH);
    assign w_is_word    = (opcode == OP_LW) | (opcode == OP_SW);
    assign w_misaligned = (w_is_half & ALU_result[0]) | (w_is_word & (ALU_result[1:0] != 2'b00));
    assign align_err    = r_align_err;
`else
    assign w_misaligned = 1'b0;
`endif

    mem_load_align u_load_align (
        .opcode (opcode),
        .addr   (ALU_result[1:0]),
        .word   (r_rdata),
        .data   (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_bus_err   <= 1'b0;
            r_align_err <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt       <= '0;
                    r_bus_err   <= 1'b0;
                    r_align_err <= 1'b0;
                    if (w_mem_op) begin
                        if (w_misaligned) begin
                            r_align_err <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= memWrite;
                            mem_addr  <= {ALU_result[31:2], 2'b00};
                            mem_be    <= byte_enable(opcode, ALU_result[1:0]);
                            mem_wdata <= store_lanes(opcode, storeData);
                            r_rdata   <= '0;
                            r_state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    // An ack arriving on the final allowed cycle still wins over the abort.
                    if (mem_ack) begin
                        r_rdata <= mem_rdata;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        r_state <= DONE;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_cnt       <= '0;
                    r_bus_err   <= 1'b0;
                    r_align_err <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_out      = 1'b0;
        opcode_out     = '0;
        funct_out      = '0;
        regWrite_out   = 1'b0;
        memtoReg_out   = 1'b0;
        dataMemrd      = '0;
        ALU_result_out = '0;
        WN_out         = '0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        stall_out = 1'b1;
                    end else begin
                        opcode_out     = opcode;
                        funct_out      = funct;
                        regWrite_out   = regWrite & valid_in;
                        memtoReg_out   = memtoReg;
                        ALU_result_out = ALU_result;
                        WN_out         = WN;
                    end
                end
                REQ: stall_out = 1'b1;
                DONE: begin
                    // EX/MEM has been frozen by the stall, so its inputs still describe this op.
                    opcode_out     = opcode;
                    funct_out      = funct;
                    regWrite_out   = regWrite & valid_in & ~r_bus_err & ~r_align_err;
                    memtoReg_out   = memtoReg;
                    ALU_result_out = ALU_result;
                    WN_out         = WN;
                    dataMemrd      = w_load_data;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access_stage
// Brief  : Directed plus random self-checking bench for mem_access_stage.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int TO = 4;

    localparam logic [5:0] T_LB  = 6'h20;
    localparam logic [5:0] T_LH  = 6'h21;
    localparam logic [5:0] T_LW  = 6'h23;
    localparam logic [5:0] T_LBU = 6'h24;
    localparam logic [5:0] T_LHU = 6'h25;
    localparam logic [5:0] T_SB  = 6'h28;
    localparam logic [5:0] T_SH  = 6'h29;
    localparam logic [5:0] T_SW  = 6'h2B;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, regWrite, memtoReg, memRead, memWrite, mem_ack;
    logic [5:0]  opcode, funct;
    logic [31:0] ALU_result, storeData, mem_rdata;
    logic [4:0]  WN;
    logic        stall_out, regWrite_out, memtoReg_out, bus_err, mem_req, mem_we;
    logic [5:0]  opcode_out, funct_out;
    logic [31:0] dataMemrd, ALU_result_out, mem_addr, mem_wdata;
    logic [4:0]  WN_out;
    logic [3:0]  mem_be;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode), .funct(funct),
        .regWrite(regWrite), .memtoReg(memtoReg), .memRead(memRead), .memWrite(memWrite),
        .ALU_result(ALU_result), .storeData(storeData), .WN(WN),
        .stall_out(stall_out), .opcode_out(opcode_out), .funct_out(funct_out),
        .regWrite_out(regWrite_out), .memtoReg_out(memtoReg_out), .dataMemrd(dataMemrd),
        .ALU_result_out(ALU_result_out), .WN_out(WN_out), .bus_err(bus_err),
`ifdef MEM_ALIGN_CHECK_EN
        .align_err(align_err),
`endif
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes decides lanes.
    function automatic int acc_size(input logic [5:0] op);
        if (op == T_LB || op == T_LBU || op == T_SB) return 1;
        if (op == T_LH || op == T_LHU || op == T_SH) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [5:0] op, input logic [1:0] a);
        int sz = acc_size(op);
        if (sz == 1) return 4'(1 << a);
        if (sz == 2) return a[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] sd);
        int sz = acc_size(op);
        if (sz == 1) return 32'(sd[7:0]) * 32'h0101_0101;
        if (sz == 2) return 32'(sd[15:0]) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [1:0] a, input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        int v;
        b = rd >> (8 * a);
        h = rd >> (16 * a[1]);
        case (op)
            T_LB:    begin v = $signed(b[7:0]);  return 32'(v); end
            T_LH:    begin v = $signed(h[15:0]); return 32'(v); end
            T_LBU:   return b & 32'hFF;
            T_LHU:   return h & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    // ack_at: REQ cycle number on which mem_ack is raised; 0 means never.
    task automatic run_mem(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] rd, input int ack_at);
        logic       is_st;
        logic       tmo;
        logic [4:0] wn;
        int         n;
        is_st = (op == T_SB) || (op == T_SH) || (op == T_SW);
        tmo   = (ack_at == 0);
        wn    = 5'($urandom_range(1, 31));
        valid_in = 1'b1; opcode = op; funct = 6'($urandom);
        regWrite = !is_st; memtoReg = !is_st; memRead = !is_st; memWrite = is_st;
        ALU_result = addr; storeData = sd; WN = wn; mem_ack = 1'b0;
        #2;
        check("issue_stall", stall_out, 1);
        check("issue_bubble_wn", WN_out, 0);
        check("issue_bubble_rw", regWrite_out, 0);
        @(posedge clk); #2;
        check("req_addr", mem_addr, {addr[31:2], 2'b00});
        check("req_be", mem_be, model_be(op, addr[1:0]));
        check("req_we", mem_we, is_st);
        if (is_st) check("req_wdata", mem_wdata, model_wdata(op, sd));
        n = 0;
        while (mem_req === 1'b1 && n < 2 * TO + 8) begin
            check("req_stall", stall_out, 1);
            n++;
            mem_ack   = (n == ack_at);
            mem_rdata = (n == ack_at) ? rd : $urandom;
            @(posedge clk); #2;
        end
        mem_ack = 1'b0;
        check("req_cycles", n, tmo ? TO : ack_at);
        check("done_stall", stall_out, 0);
        check("done_wn", WN_out, wn);
        check("done_opcode", opcode_out, op);
        check("done_regwrite", regWrite_out, !is_st && !tmo);
        check("done_memtoreg", memtoReg_out, !is_st);
        check("done_buserr", bus_err, tmo);
        if (!is_st && !tmo) check("done_data", dataMemrd, model_load(op, addr[1:0], rd));
        @(posedge clk); #2;
        valid_in = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        #1;
        check("after_buserr", bus_err, 0);
        check("after_stall", stall_out, 0);
        @(posedge clk); #2;
    endtask

    initial begin
        logic [5:0]  ops [8];
        logic [5:0]  op;
        logic [31:0] a;
        ops = '{T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SB, T_SH, T_SW};

        // Reset with a live non-memory instruction presented.
        rst = 1'b1; valid_in = 1'b1; opcode = 6'h00; funct = 6'h20; regWrite = 1'b1;
        memtoReg = 1'b0; memRead = 1'b0; memWrite = 1'b0; ALU_result = 32'h1234;
        storeData = 32'h0; WN = 5'd5; mem_ack = 1'b0; mem_rdata = 32'h0;
        #2;
        check("rst_alu", ALU_result_out, 0);
        check("rst_rw", regWrite_out, 0);
        check("rst_wn", WN_out, 0);
        check("rst_req", mem_req, 0);
        check("rst_be", mem_be, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_buserr", bus_err, 0);
        #10 rst = 1'b0;
        @(posedge clk); #2;

        // Zero-latency pass-through.
        check("pt_alu", ALU_result_out, 32'h1234);
        check("pt_wn", WN_out, 5);
        check("pt_rw", regWrite_out, 1);
        check("pt_funct", funct_out, 6'h20);
        check("pt_stall", stall_out, 0);
        check("pt_data", dataMemrd, 0);
        @(posedge clk); #2;
        check("pt_noreq", mem_req, 0);
        valid_in = 1'b0; memRead = 1'b1;
        #1;
        check("pt_invalid_rw", regWrite_out, 0);
        check("pt_invalid_stall", stall_out, 0);
        memRead = 1'b0;
        @(posedge clk); #2;

        // Directed memory operations.
        run_mem(T_LW,  32'h100, 32'h0, 32'hDEADBEEF, 2);
        run_mem(T_LB,  32'h103, 32'h0, 32'h80FF_FFFF, 1);
        run_mem(T_LBU, 32'h103, 32'h0, 32'h80FF_FFFF, 1);
        run_mem(T_SH,  32'h202, 32'h0000_ABCD, 32'h0, 1);
        run_mem(T_LW,  32'h300, 32'h0, 32'h0, 0);
`ifndef MEM_ALIGN_CHECK_EN
        run_mem(T_LH,  32'h103, 32'h0, 32'h8001_0000, 3);
`endif

        // Reset while a request is outstanding.
        valid_in = 1'b1; opcode = T_LW; regWrite = 1'b1; memtoReg = 1'b1;
        memRead = 1'b1; memWrite = 1'b0; ALU_result = 32'h400;
        @(posedge clk); #2;
        check("midrst_req_before", mem_req, 1);
        rst = 1'b1;
        #1;
        check("midrst_req", mem_req, 0);
        check("midrst_stall", stall_out, 0);
        check("midrst_rw", regWrite_out, 0);
        valid_in = 1'b0; memRead = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #2;
        mem_ack = 1'b0;
        check("late_ack_req", mem_req, 0);
        check("late_ack_stall", stall_out, 0);
        check("late_ack_buserr", bus_err, 0);
        @(posedge clk); #2;

`ifdef MEM_ALIGN_CHECK_EN
        valid_in = 1'b1; opcode = T_LW; regWrite = 1'b1; memtoReg = 1'b1;
        memRead = 1'b1; memWrite = 1'b0; ALU_result = 32'h102; WN = 5'd9;
        #1;
        check("al_issue_stall", stall_out, 1);
        @(posedge clk); #2;
        check("al_noreq", mem_req, 0);
        check("al_err", align_err, 1);
        check("al_rw", regWrite_out, 0);
        check("al_stall", stall_out, 0);
        @(posedge clk); #2;
        valid_in = 1'b0; memRead = 1'b0;
        #1;
        check("al_err_clear", align_err, 0);
        @(posedge clk); #2;
`endif

        // Random accesses against the reference model.
        for (int i = 0; i < 16; i++) begin
            op = ops[$urandom_range(0, 7)];
            a  = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
            if (acc_size(op) == 2) a[0] = 1'b0;
            if (acc_size(op) == 4) a[1:0] = 2'b00;
`endif
            run_mem(op, a, $urandom, $urandom, $urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
